// File: rtl/demux_bank.sv
// demux_bank: registered 1-to-32 write demultiplexer with a timed clear sweep.
// Optional burst mode (consecutive-entry writes) is enabled by `DEMUX_BURST_EN.
module demux_bank #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       select,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clr,
    input  logic             burst_start,
    input  logic [5:0]       burst_len,
    output logic             busy,
    output logic             err,
    output logic [DEPTH-1:0] written,
    output logic [WIDTH-1:0] out0,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic [WIDTH-1:0] out3,
    output logic [WIDTH-1:0] out4,
    output logic [WIDTH-1:0] out5,
    output logic [WIDTH-1:0] out6,
    output logic [WIDTH-1:0] out7,
    output logic [WIDTH-1:0] out8,
    output logic [WIDTH-1:0] out9,
    output logic [WIDTH-1:0] out10,
    output logic [WIDTH-1:0] out11,
    output logic [WIDTH-1:0] out12,
    output logic [WIDTH-1:0] out13,
    output logic [WIDTH-1:0] out14,
    output logic [WIDTH-1:0] out15,
    output logic [WIDTH-1:0] out16,
    output logic [WIDTH-1:0] out17,
    output logic [WIDTH-1:0] out18,
    output logic [WIDTH-1:0] out19,
    output logic [WIDTH-1:0] out20,
    output logic [WIDTH-1:0] out21,
    output logic [WIDTH-1:0] out22,
    output logic [WIDTH-1:0] out23,
    output logic [WIDTH-1:0] out24,
    output logic [WIDTH-1:0] out25,
    output logic [WIDTH-1:0] out26,
    output logic [WIDTH-1:0] out27,
    output logic [WIDTH-1:0] out28,
    output logic [WIDTH-1:0] out29,
    output logic [WIDTH-1:0] out30,
    output logic [WIDTH-1:0] out31
);

`ifdef DEMUX_BURST_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        BURST = 2'd2
    } state_e;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1
    } state_e;
`endif

    state_e           state_q, state_d;
    logic [4:0]       cnt_q, cnt_d;
    logic             err_q, err_d;
    logic [DEPTH-1:0] written_q, written_d;
    logic [WIDTH-1:0] out_q [DEPTH];
    logic [WIDTH-1:0] out_d [DEPTH];

`ifdef DEMUX_BURST_EN
    logic [4:0]       ptr_q, ptr_d;
    logic [5:0]       rem_q, rem_d;
`else
    logic             unused_burst;
    assign unused_burst = ^{burst_start, burst_len};
`endif

    logic             accept;
    logic             wr_en;
    logic [4:0]       wr_idx;
    logic [WIDTH-1:0] wr_val;
    logic             wr_flag;

`ifdef DEMUX_BURST_EN
    assign in_ready = ((state_q == IDLE) && !clr) || (state_q == BURST);
`else
    assign in_ready = (state_q == IDLE) && !clr;
`endif
    assign accept = in_valid && in_ready;
    assign busy   = (state_q != IDLE);
    assign err    = err_q;

    // At most one entry changes per cycle, so the FSM picks a single write port.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = select[4:0];
        wr_val  = in_data;
        wr_flag = 1'b1;
`ifdef DEMUX_BURST_EN
        ptr_d   = ptr_q;
        rem_d   = rem_q;
`endif
        case (state_q)
            IDLE: begin
                if (clr) begin
                    state_d = CLEAR;
                    cnt_d   = 5'd0;
                end else if (accept) begin
`ifdef DEMUX_BURST_EN
                    if (burst_start) begin
                        if ((burst_len == 6'd0) || select[5]) begin
                            err_d = 1'b1;
                        end else begin
                            wr_en = 1'b1;
                            if (burst_len != 6'd1) begin
                                ptr_d   = select[4:0];
                                rem_d   = burst_len - 6'd1;
                                state_d = BURST;
                            end
                        end
                    end else
`endif
                    if (select[5]) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            CLEAR: begin
                wr_en   = 1'b1;
                wr_idx  = cnt_q;
                wr_val  = '0;
                wr_flag = 1'b0;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = IDLE;
                end
            end
`ifdef DEMUX_BURST_EN
            BURST: begin
                if (accept) begin
                    wr_en  = 1'b1;
                    wr_idx = ptr_q + 5'd1;
                    ptr_d  = ptr_q + 5'd1;
                    rem_d  = rem_q - 6'd1;
                    if (rem_q == 6'd1) begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        written_d = written_q;
        if (wr_en) begin
            written_d[wr_idx] = wr_flag;
        end
        for (int i = 0; i < DEPTH; i++) begin
            out_d[i] = (wr_en && (wr_idx == 5'(i))) ? wr_val : out_q[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            err_q     <= 1'b0;
            written_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                out_q[i] <= '0;
            end
`ifdef DEMUX_BURST_EN
            ptr_q     <= 5'd0;
            rem_q     <= 6'd0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            written_q <= written_d;
            for (int i = 0; i < DEPTH; i++) begin
                out_q[i] <= out_d[i];
            end
`ifdef DEMUX_BURST_EN
            ptr_q     <= ptr_d;
            rem_q     <= rem_d;
`endif
        end
    end

    assign written = written_q;
    assign out0  = out_q[0];
    assign out1  = out_q[1];
    assign out2  = out_q[2];
    assign out3  = out_q[3];
    assign out4  = out_q[4];
    assign out5  = out_q[5];
    assign out6  = out_q[6];
    assign out7  = out_q[7];
    assign out8  = out_q[8];
    assign out9  = out_q[9];
    assign out10 = out_q[10];
    assign out11 = out_q[11];
    assign out12 = out_q[12];
    assign out13 = out_q[13];
    assign out14 = out_q[14];
    assign out15 = out_q[15];
    assign out16 = out_q[16];
    assign out17 = out_q[17];
    assign out18 = out_q[18];
    assign out19 = out_q[19];
    assign out20 = out_q[20];
    assign out21 = out_q[21];
    assign out22 = out_q[22];
    assign out23 = out_q[23];
    assign out24 = out_q[24];
    assign out25 = out_q[25];
    assign out26 = out_q[26];
    assign out27 = out_q[27];
    assign out28 = out_q[28];
    assign out29 = out_q[29];
    assign out30 = out_q[30];
    assign out31 = out_q[31];

endmodule
